// File: rtl/fpga_mem_pkg.sv
// Shared types and constants for the memory-side endpoint of the FPGA memory link.
package fpga_mem_pkg;

  localparam int unsigned DATA_W        = 32;
  localparam int unsigned BYTE_OFFSET_W = 2;

  localparam logic [DATA_W-1:0] IDLE_BUS_PATTERN = 32'hDEADBEEF;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_DATA = 3'd1,
    WR_ACK  = 3'd2,
    RD_WAIT = 3'd3,
    RD_ADDR = 3'd4,
    RD_DATA = 3'd5
  } fpga_mem_state_t;

endpackage

// File: rtl/fpga_mem_array.sv
// Single-port synchronous word RAM with one-cycle read latency and write-first behaviour.
module fpga_mem_array
  import fpga_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  // Contents are deliberately never reset so data survives a link reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[addr_i] <= wdata_i;
      rdata_o     <= wdata_i;
    end else begin
      rdata_o <= mem[addr_i];
    end
  end

endmodule

// File: rtl/fpga_mem_responder.sv
// Memory-side burst endpoint: captures read/write commands, serves aligned bursts from an internal array.
module fpga_mem_responder
  import fpga_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS  = 1024,
  parameter int unsigned BURST_WORDS  = 8,
  parameter int unsigned READ_LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] address_data_bus_c_to_m,
  input  logic              address_on_c_to_m,
  input  logic              data_on_c_to_m,
  input  logic              read_en_c_to_m,
  input  logic              write_en_c_to_m,
  input  logic              resp_c_to_m,
  output logic [DATA_W-1:0] address_data_bus_m_to_c,
  output logic              address_on_m_to_c,
  output logic              data_on_m_to_c,
  output logic              read_en_m_to_c,
  output logic              write_en_m_to_c,
  output logic              resp_m_to_c
);

  localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
  localparam int unsigned BEAT_W = (BURST_WORDS > 1) ? $clog2(BURST_WORDS) : 1;
  localparam int unsigned LAT_W  = $clog2(READ_LATENCY + 1);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_WORDS - 1);
  localparam logic [IDX_W-1:0]  LINE_MASK = ~IDX_W'(BURST_WORDS - 1);
  localparam logic [LAT_W-1:0]  LAT_LOAD  = (READ_LATENCY > 1) ? LAT_W'(READ_LATENCY - 2) : '0;

  fpga_mem_state_t   state_q,   state_d;
  logic [IDX_W-1:0]  baseIdx_q, baseIdx_d;
  logic [BEAT_W-1:0] beat_q,    beat_d;
  logic [LAT_W-1:0]  latCnt_q,  latCnt_d;

  logic [DATA_W-1:0] busOut_q,  busOut_d;
  logic              addrOn_q,  addrOn_d;
  logic              dataOn_q,  dataOn_d;
  logic              readEn_q,  readEn_d;
  logic              writeEn_q, writeEn_d;
  logic              resp_q,    resp_d;

  logic              memWe;
  logic [IDX_W-1:0]  memAddr;
  logic [DATA_W-1:0] memRdata;
  logic [IDX_W-1:0]  cmdIdx;
  logic              unusedResp;

  assign unusedResp = resp_c_to_m;
  assign cmdIdx     = address_data_bus_c_to_m[IDX_W+1:BYTE_OFFSET_W] & LINE_MASK;

  fpga_mem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk    (clk),
    .we_i   (memWe),
    .addr_i (memAddr),
    .wdata_i(address_data_bus_c_to_m),
    .rdata_o(memRdata)
  );

  // Outputs are computed from the current state and registered, so every response lags its state by one cycle.
  always_comb begin
    state_d   = state_q;
    baseIdx_d = baseIdx_q;
    beat_d    = beat_q;
    latCnt_d  = latCnt_q;
    memWe     = 1'b0;
    memAddr   = baseIdx_q + IDX_W'(beat_q);
    busOut_d  = IDLE_BUS_PATTERN;
    addrOn_d  = 1'b0;
    dataOn_d  = 1'b0;
    readEn_d  = 1'b0;
    writeEn_d = 1'b0;
    resp_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (address_on_c_to_m && (read_en_c_to_m != write_en_c_to_m)) begin
          baseIdx_d = cmdIdx;
          beat_d    = '0;
          latCnt_d  = LAT_LOAD;
          if (write_en_c_to_m) begin
            state_d = WR_DATA;
          end else begin
            state_d = (READ_LATENCY > 1) ? RD_WAIT : RD_ADDR;
          end
        end
      end
      WR_DATA: begin
        if (data_on_c_to_m) begin
          memWe  = !rst;
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) state_d = WR_ACK;
        end
      end
      WR_ACK: begin
        writeEn_d = 1'b1;
        resp_d    = 1'b1;
        state_d   = IDLE;
      end
      RD_WAIT: begin
        if (latCnt_q == '0) state_d = RD_ADDR;
        else                latCnt_d = latCnt_q - 1'b1;
      end
      RD_ADDR: begin
        busOut_d = DATA_W'({baseIdx_q, {BYTE_OFFSET_W{1'b0}}});
        addrOn_d = 1'b1;
        readEn_d = 1'b1;
        memAddr  = baseIdx_q;
        state_d  = RD_DATA;
      end
      RD_DATA: begin
        // The array output holds the word fetched last cycle; fetch the next one now to keep beats gapless.
        busOut_d = memRdata;
        dataOn_d = 1'b1;
        readEn_d = 1'b1;
        memAddr  = baseIdx_q + IDX_W'(beat_q) + 1'b1;
        beat_d   = beat_q + 1'b1;
        if (beat_q == LAST_BEAT) begin
          resp_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      baseIdx_q <= '0;
      beat_q    <= '0;
      latCnt_q  <= '0;
      busOut_q  <= IDLE_BUS_PATTERN;
      addrOn_q  <= 1'b0;
      dataOn_q  <= 1'b0;
      readEn_q  <= 1'b0;
      writeEn_q <= 1'b0;
      resp_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      baseIdx_q <= baseIdx_d;
      beat_q    <= beat_d;
      latCnt_q  <= latCnt_d;
      busOut_q  <= busOut_d;
      addrOn_q  <= addrOn_d;
      dataOn_q  <= dataOn_d;
      readEn_q  <= readEn_d;
      writeEn_q <= writeEn_d;
      resp_q    <= resp_d;
    end
  end

  assign address_data_bus_m_to_c = busOut_q;
  assign address_on_m_to_c       = addrOn_q;
  assign data_on_m_to_c          = dataOn_q;
  assign read_en_m_to_c          = readEn_q;
  assign write_en_m_to_c         = writeEn_q;
  assign resp_m_to_c             = resp_q;

endmodule

// File: doc/fpga_mem_responder.md
# fpga_mem_responder

Memory-side endpoint of the 32-bit multiplexed FPGA memory link.
- Accepts read and write burst commands from the cache-side controller on the `*_c_to_m` signals.
- Stores and returns data from an internal word-addressed array.
- Drives responses back on the `*_m_to_c` signals.
- Stands in for the board memory in simulation and in FPGA bring-up builds.

## Interface
Parameters:
- `DEPTH_WORDS`, 1024: array depth in 32-bit words; power of two.
- `BURST_WORDS`, 8: data words per transaction (one 256-bit cache line).
- `READ_LATENCY`, 4: cycles from read-address capture to address echo; must be ≥1.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset; synchronous, active-high.
- `address_data_bus_c_to_m` in 32: address or write-data word from the controller.
- `address_on_c_to_m` in 1: bus carries a command address this cycle.
- `data_on_c_to_m` in 1: bus carries a write-data word this cycle.
- `read_en_c_to_m` in 1: command is a read; sampled with `address_on`.
- `write_en_c_to_m` in 1: command is a write; sampled with `address_on`.
- `resp_c_to_m` in 1: reserved; ignored.
- `address_data_bus_m_to_c` out 32: echoed address or read-data word.
- `address_on_m_to_c` out 1: echo-address cycle of a read response.
- `data_on_m_to_c` out 1: read-data word valid.
- `read_en_m_to_c` out 1: high on every cycle of a read response (echo and data).
- `write_en_m_to_c` out 1: high with the write-ack pulse.
- `resp_m_to_c` out 1: transaction complete (last read word or write ack).

## Operation
- FSM states:
  - `IDLE`
  - `WR_DATA`
  - `WR_ACK`
  - `RD_WAIT`
  - `RD_ADDR`
  - `RD_DATA`
- Address handling:
  - Addresses are byte addresses.
  - Word index = `addr[log2(DEPTH_WORDS)+1:2]`.
  - Low bits inside the burst (`log2(BURST_WORDS)+2` bits) are forced to zero, so bursts are always aligned.
  - Index arithmetic wraps modulo `DEPTH_WORDS`.
- `IDLE` state:
  - `address_on` with `write_en` only: latch the base index and clear the beat count, then go to `WR_DATA`.
  - `address_on` with `read_en` only: latch the base index and load the latency counter, then go to `RD_WAIT`.
  - `address_on` with both or neither of `read_en`/`write_en`: command is dropped and the FSM stays in `IDLE`.
  - `data_on` while in `IDLE`: ignored.
- `WR_DATA` state:
  - Each cycle with `data_on` high writes the bus word to `base+beat` and increments `beat`.
  - Gaps (cycles with `data_on` low) are allowed.
  - After beat `BURST_WORDS-1` is written, go to `WR_ACK`.
- `WR_ACK` state: one cycle with `resp_m_to_c` and `write_en_m_to_c` high, then back to `IDLE`.
- `RD_WAIT` state: decrement the latency counter; go to `RD_ADDR` so the echo appears exactly `READ_LATENCY` cycles after capture.
- `RD_ADDR` state:
  - Drive the aligned address with `address_on_m_to_c` and `read_en_m_to_c` high.
  - Issue the array read for beat 0.
- `RD_DATA` state:
  - `BURST_WORDS` consecutive cycles, with `data_on_m_to_c` and `read_en_m_to_c` high.
  - Words come from `base+0 .. base+BURST_WORDS-1`.
  - `resp_m_to_c` is high on the last word only.
  - There is no backpressure.
- Commands arriving in any state other than `IDLE` are ignored.
- Reset value of every output:
  - Bus = `32'hDEADBEEF`.
  - All strobes = 0.
- The bus returns to `32'hDEADBEEF` whenever no response is being driven.
- Reset mid-transaction:
  - Return to `IDLE` on the next edge and drop the transaction.
  - Array contents are retained; the array itself is never reset.

## Timing
- All outputs are registered.
- Write command captured at edge T:
  - Data beats are accepted from edge T+1 onward.
  - If the last beat is captured at edge W, the ack is visible in cycle W+1.
- Read command captured at edge T:
  - Echo is visible in cycle T+`READ_LATENCY`.
  - Data is visible in cycles T+`READ_LATENCY`+1 .. T+`READ_LATENCY`+`BURST_WORDS`.
- Back-to-back transactions:
  - A new command is accepted in the cycle right after `WR_ACK`, or right after the last read word.
  - A read that follows a write to the same line returns the newly written data.

## Structure
- Package `fpga_mem_pkg` holds:
  - The state enum `fpga_mem_state_t`.
  - `IDLE_BUS_PATTERN = 32'hDEADBEEF`.
  - The width helper constants.
- Sub-module `fpga_mem_array`:
  - Single-port synchronous RAM, 32-bit words, `DEPTH_WORDS` deep.
  - One-cycle read latency, write-first.
  - The FSM prefetches one word ahead so `RD_DATA` stays gapless.

## Test plan
- Reset with `rst` held 3 cycles:
  - Bus reads `32'hDEADBEEF` and all strobes are 0.
  - A command on the first cycle after reset is accepted.
- Write at address `0x0000_0040` with data `0x1..0x8`, then a read of `0x40`:
  - Ack lands one cycle after beat 8.
  - Echo `0x40` appears at T+4.
  - Data `0x1..0x8` follows, with `resp` on `0x8`.
- Write with 2-cycle gaps between data beats:
  - Exactly 8 words are stored.
  - Ack lands one cycle after the final beat.
- Read at `0x0000_0047` (unaligned) and at `4*DEPTH_WORDS+0x40`:
  - Echo is `0x40`-aligned.
  - Data aliases onto line `0x40`.
- Command with both `read_en` and `write_en` set, and a new read issued during `RD_DATA`:
  - Both are ignored; the outputs match the reference model.
- `rst` asserted during `RD_DATA` beat 3:
  - Outputs are at reset values in the next cycle.
  - A following read returns the previously written contents.
